uart_cmd_wrapper: RTL

- DUT-side responder for the host command link; the host (CommMaster) is the initiator on the same 8N1 UART link.
- Receives two serial bytes, high byte first, on RX and assembles them into a 16-bit command for cmd_cfg.
- Serializes cmd_cfg's 8-bit response (e.g. 8'hA5 ack) back on TX.
- Sits between the LA_dig RX/TX pins and cmd_cfg.

---
 rtl/uart_cmd_wrapper.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_wrapper.sv
// 8N1 UART responder: assembles two received bytes (high first) into a 16-bit command
// and serializes a single response byte back to the host.
module uart_cmd_wrapper #(
    parameter logic [15:0] BAUD_CNT    = 16'd868,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy
);

    localparam logic [15:0] BaudLast = BAUD_CNT - 16'd1;
    localparam logic [15:0] HalfLast = (BAUD_CNT >> 1) - 16'd1;
    localparam logic [23:0] ToLast   = TIMEOUT_CYC - 24'd1;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {AsmWaitHi, AsmWaitLo} asm_state_e;
    typedef enum logic {TxIdle, TxXmit} tx_state_e;

    // ---------------- RX synchronizer and byte receiver ----------------
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_ok_q, rx_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_ok_q    <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_ok_q  <= 1'b0;
            rx_err_q <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= 16'd0;
                    end
                end
                RxStart: begin
                    // Line back high at half a bit means the start edge was a glitch.
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q   <= 16'd0;
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BaudLast) begin
                        rx_cnt_q   <= 16'd0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RxStop;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BaudLast) begin
                        rx_cnt_q   <= 16'd0;
                        rx_state_q <= RxIdle;
                        rx_ok_q    <= rx_sync_q;
                        rx_err_q   <= !rx_sync_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // ---------------- command assembly ----------------
    asm_state_e  asm_state_q;
    logic [7:0]  hi_q;
    logic [23:0] to_cnt_q;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;
    logic        cmd_set;
    logic        cmd_rdy_d;

    always_comb begin
        cmd_set   = (asm_state_q == AsmWaitLo) && rx_ok_q;
        // A completing command beats a simultaneous clear.
        cmd_rdy_d = cmd_set | (cmd_rdy_q & ~clr_cmd_rdy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state_q <= AsmWaitHi;
            hi_q        <= 8'h00;
            to_cnt_q    <= 24'd0;
            cmd_q       <= 16'h0000;
            cmd_rdy_q   <= 1'b0;
        end else begin
            cmd_rdy_q <= cmd_rdy_d;
            unique case (asm_state_q)
                AsmWaitHi: begin
                    if (rx_ok_q) begin
                        hi_q        <= rx_shift_q;
                        to_cnt_q    <= 24'd0;
                        asm_state_q <= AsmWaitLo;
                    end
                end
                AsmWaitLo: begin
                    if (rx_ok_q) begin
                        cmd_q       <= {hi_q, rx_shift_q};
                        asm_state_q <= AsmWaitHi;
                    end else if (rx_err_q) begin
                        asm_state_q <= AsmWaitHi;
                    end else if (rx_state_q == RxIdle) begin
                        if (to_cnt_q == ToLast) begin
                            asm_state_q <= AsmWaitHi;
                        end else begin
                            to_cnt_q <= to_cnt_q + 24'd1;
                        end
                    end
                end
                default: asm_state_q <= AsmWaitHi;
            endcase
        end
    end

    // ---------------- response transmitter ----------------
    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [3:0]  tx_bit_q;
    logic [8:0]  tx_shift_q;
    logic        tx_q, tx_busy_q, resp_sent_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= 16'd0;
            tx_bit_q    <= 4'd0;
            tx_shift_q  <= 9'h1ff;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            resp_sent_q <= 1'b0;
            unique case (tx_state_q)
                TxIdle: begin
                    if (send_resp) begin
                        tx_shift_q <= {1'b1, resp};
                        tx_q       <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_cnt_q   <= 16'd0;
                        tx_bit_q   <= 4'd0;
                        tx_state_q <= TxXmit;
                    end
                end
                TxXmit: begin
                    if (tx_cnt_q == BaudLast) begin
                        tx_cnt_q <= 16'd0;
                        if (tx_bit_q == 4'd9) begin
                            tx_state_q  <= TxIdle;
                            tx_busy_q   <= 1'b0;
                            resp_sent_q <= 1'b1;
                            tx_q        <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 4'd1;
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    assign TX        = tx_q;
    assign tx_busy   = tx_busy_q;
    assign resp_sent = resp_sent_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;

endmodule
